// File: rtl/wb_regfile.sv
// wb_regfile: Y86 architectural register file with dual write-back commit,
// two bypassed read ports, a raw debug read port and a committed-write counter.
module wb_regfile #(
    parameter int          NREG     = 8,
    parameter int          RSP_ID   = 4,
    parameter logic [31:0] RSP_INIT = 32'h0000_0000,
    parameter logic [7:0]  RNONE    = 8'h0F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_stall,
    input  logic [31:0] wb_valE,
    input  logic [31:0] wb_valM,
    input  logic [7:0]  wb_dstE,
    input  logic [7:0]  wb_dstM,
    input  logic [7:0]  srcA,
    input  logic [7:0]  srcB,
    output logic [31:0] valA,
    output logic [31:0] valB,
    input  logic [7:0]  dbg_id,
    output logic [31:0] dbg_val,
    output logic [31:0] wr_count
);
    localparam int         IW     = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [7:0] NREG_B = 8'(NREG);

    logic [31:0] r_regs [NREG];
    logic [31:0] r_count;
    logic        w_we_e;
    logic        w_we_m;
    logic        w_same;
    logic [31:0] w_inc;

    // Writes are gated by rst so bypass is also suppressed while reset is held.
    assign w_we_e = rst && !wb_stall && wb_dstE != RNONE && wb_dstE < NREG_B;
    assign w_we_m = rst && !wb_stall && wb_dstM != RNONE && wb_dstM < NREG_B;
    assign w_same = w_we_e && w_we_m && wb_dstE == wb_dstM;
    assign w_inc  = 32'(w_we_e && !w_same) + 32'(w_we_m);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= (i == RSP_ID) ? RSP_INIT : '0;
            r_count <= '0;
        end else begin
            if (w_we_e)
                r_regs[wb_dstE[IW-1:0]] <= wb_valE;
            // M port is written last so it wins on a shared destination.
            if (w_we_m)
                r_regs[wb_dstM[IW-1:0]] <= wb_valM;
            r_count <= r_count + w_inc;
        end
    end

    assign valA = (srcA >= NREG_B) ? '0 :
                  (w_we_m && wb_dstM == srcA) ? wb_valM :
                  (w_we_e && wb_dstE == srcA) ? wb_valE :
                  r_regs[srcA[IW-1:0]];

    assign valB = (srcB >= NREG_B) ? '0 :
                  (w_we_m && wb_dstM == srcB) ? wb_valM :
                  (w_we_e && wb_dstE == srcB) ? wb_valE :
                  r_regs[srcB[IW-1:0]];

    assign dbg_val  = (dbg_id >= NREG_B) ? '0 : r_regs[dbg_id[IW-1:0]];
    assign wr_count = r_count;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and randomized checks of wb_regfile against an
// array-based model of the register file and commit counter.
`timescale 1ns/1ps
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_stall;
    logic [31:0] wb_valE, wb_valM;
    logic [7:0]  wb_dstE, wb_dstM, srcA, srcB, dbg_id;
    logic [31:0] valA, valB, dbg_val, wr_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [8];
    logic [31:0] m_count;

    wb_regfile #(.NREG(8), .RSP_ID(4), .RSP_INIT(32'h100), .RNONE(8'h0F)) dut (
        .clk(clk), .rst(rst), .wb_stall(wb_stall),
        .wb_valE(wb_valE), .wb_valM(wb_valM), .wb_dstE(wb_dstE), .wb_dstM(wb_dstM),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .dbg_id(dbg_id), .dbg_val(dbg_val), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = (i == 4) ? 32'h100 : 32'h0;
        m_count = 0;
    endtask

    task automatic model_commit();
        bit e, m;
        e = !wb_stall && wb_dstE < 8;
        m = !wb_stall && wb_dstM < 8;
        if (e) m_regs[wb_dstE[2:0]] = wb_valE;
        if (m) m_regs[wb_dstM[2:0]] = wb_valM;
        if (e && m && wb_dstE == wb_dstM) m_count = m_count + 1;
        else m_count = m_count + 32'(e) + 32'(m);
    endtask

    function automatic logic [31:0] exp_rd(input logic [7:0] id, input bit byp);
        if (id >= 8) return 32'h0;
        if (byp && !wb_stall && wb_dstM == id) return wb_valM;
        if (byp && !wb_stall && wb_dstE == id) return wb_valE;
        return m_regs[id[2:0]];
    endfunction

    task automatic drive(input logic st, input logic [7:0] de, input logic [31:0] ve,
                         input logic [7:0] dm, input logic [31:0] vm,
                         input logic [7:0] sa, input logic [7:0] sb);
        wb_stall = st; wb_dstE = de; wb_valE = ve; wb_dstM = dm; wb_valM = vm;
        srcA = sa; srcB = sb;
    endtask

    task automatic edge_commit();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive(0, 8'h0F, 0, 8'h0F, 0, 8'd4, 8'd0);
        #1;
        checks++; if (valA !== 32'h100) begin errors++; $display("FAIL reset_esp: got %h expected %h", valA, 32'h100); end
        checks++; if (valB !== 32'h0) begin errors++; $display("FAIL reset_eax: got %h expected %h", valB, 32'h0); end
        checks++; if (wr_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %h expected %h", wr_count, 32'h0); end
        for (int i = 0; i < 8; i++) begin
            dbg_id = 8'(i); #0.5;
            checks++; if (dbg_val !== m_regs[i]) begin errors++; $display("FAIL reset_dbg%0d: got %h expected %h", i, dbg_val, m_regs[i]); end
        end
    endtask

    task automatic test_dual_write();
        @(negedge clk);
        drive(0, 8'd1, 32'h11, 8'd2, 32'h22, 8'd1, 8'd2);
        #1;
        checks++; if (valA !== 32'h11) begin errors++; $display("FAIL dual_bypass_a: got %h expected %h", valA, 32'h11); end
        checks++; if (valB !== 32'h22) begin errors++; $display("FAIL dual_bypass_b: got %h expected %h", valB, 32'h22); end
        edge_commit();
        dbg_id = 8'd1; #0.5;
        checks++; if (dbg_val !== 32'h11) begin errors++; $display("FAIL dual_reg1: got %h expected %h", dbg_val, 32'h11); end
        dbg_id = 8'd2; #0.5;
        checks++; if (dbg_val !== 32'h22) begin errors++; $display("FAIL dual_reg2: got %h expected %h", dbg_val, 32'h22); end
        checks++; if (wr_count !== 32'd2) begin errors++; $display("FAIL dual_count: got %0d expected %0d", wr_count, 2); end
    endtask

    task automatic test_same_dst();
        @(negedge clk);
        drive(0, 8'd4, 32'hFC, 8'd4, 32'hAA, 8'd4, 8'd4);
        #1;
        checks++; if (valA !== 32'hAA) begin errors++; $display("FAIL same_bypass: got %h expected %h", valA, 32'hAA); end
        edge_commit();
        dbg_id = 8'd4; #0.5;
        checks++; if (dbg_val !== 32'hAA) begin errors++; $display("FAIL same_reg4: got %h expected %h", dbg_val, 32'hAA); end
        checks++; if (wr_count !== 32'd3) begin errors++; $display("FAIL same_count: got %0d expected %0d", wr_count, 3); end
    endtask

    task automatic test_stall();
        @(negedge clk);
        drive(1, 8'd3, 32'h33, 8'h0F, 32'h0, 8'd3, 8'd3);
        #1;
        checks++; if (valA !== 32'h0) begin errors++; $display("FAIL stall_nobypass: got %h expected %h", valA, 32'h0); end
        edge_commit();
        dbg_id = 8'd3; #0.5;
        checks++; if (dbg_val !== 32'h0) begin errors++; $display("FAIL stall_reg3: got %h expected %h", dbg_val, 32'h0); end
        checks++; if (wr_count !== 32'd3) begin errors++; $display("FAIL stall_count: got %0d expected %0d", wr_count, 3); end
        @(negedge clk);
        wb_stall = 0;
        edge_commit();
        checks++; if (dbg_val !== 32'h33) begin errors++; $display("FAIL unstall_reg3: got %h expected %h", dbg_val, 32'h33); end
        checks++; if (wr_count !== 32'd4) begin errors++; $display("FAIL unstall_count: got %0d expected %0d", wr_count, 4); end
    endtask

    task automatic test_invalid();
        logic [31:0] cnt0;
        cnt0 = wr_count;
        @(negedge clk);
        drive(0, 8'h0F, 32'hDEAD, 8'h09, 32'hBEEF, 8'h0F, 8'h09);
        #1;
        checks++; if (valA !== 32'h0) begin errors++; $display("FAIL inv_rnone_read: got %h expected %h", valA, 32'h0); end
        checks++; if (valB !== 32'h0) begin errors++; $display("FAIL inv_oob_read: got %h expected %h", valB, 32'h0); end
        edge_commit();
        checks++; if (wr_count !== cnt0) begin errors++; $display("FAIL inv_count: got %0d expected %0d", wr_count, cnt0); end
        for (int i = 0; i < 8; i++) begin
            dbg_id = 8'(i); #0.5;
            checks++; if (dbg_val !== m_regs[i]) begin errors++; $display("FAIL inv_reg%0d: got %h expected %h", i, dbg_val, m_regs[i]); end
        end
        dbg_id = 8'h0F; #0.5;
        checks++; if (dbg_val !== 32'h0) begin errors++; $display("FAIL inv_dbg_rnone: got %h expected %h", dbg_val, 32'h0); end
    endtask

    task automatic test_random();
        logic [7:0] ids [10] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'h0F, 8'h09};
        logic [31:0] ea, eb;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            drive(($urandom_range(0, 4) == 0), ids[$urandom_range(0, 9)], $urandom,
                  ids[$urandom_range(0, 9)], $urandom, ids[$urandom_range(0, 9)], ids[$urandom_range(0, 9)]);
            if ($urandom_range(0, 3) == 0) wb_dstM = wb_dstE;
            #1;
            ea = exp_rd(srcA, 1);
            eb = exp_rd(srcB, 1);
            checks++; if (valA !== ea) begin errors++; $display("FAIL rnd_valA[%0d]: got %h expected %h", n, valA, ea); end
            checks++; if (valB !== eb) begin errors++; $display("FAIL rnd_valB[%0d]: got %h expected %h", n, valB, eb); end
            edge_commit();
            dbg_id = ids[$urandom_range(0, 9)]; #0.5;
            ea = exp_rd(dbg_id, 0);
            checks++; if (dbg_val !== ea) begin errors++; $display("FAIL rnd_dbg[%0d]: got %h expected %h", n, dbg_val, ea); end
            checks++; if (wr_count !== m_count) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, wr_count, m_count); end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(0, 8'd4, 32'h5555, 8'd0, 32'h6666, 8'd4, 8'd0);
        #2;
        rst = 0;
        model_reset();
        #0.2;
        for (int i = 0; i < 8; i++) begin
            dbg_id = 8'(i); #0.2;
            checks++; if (dbg_val !== m_regs[i]) begin errors++; $display("FAIL arst_reg%0d: got %h expected %h", i, dbg_val, m_regs[i]); end
        end
        checks++; if (wr_count !== 32'h0) begin errors++; $display("FAIL arst_count: got %0d expected %0d", wr_count, 0); end
        checks++; if (valA !== 32'h100) begin errors++; $display("FAIL arst_nobypass_a: got %h expected %h", valA, 32'h100); end
        checks++; if (valB !== 32'h0) begin errors++; $display("FAIL arst_nobypass_b: got %h expected %h", valB, 32'h0); end
        @(posedge clk); #1;
        dbg_id = 8'd4; #0.5;
        checks++; if (dbg_val !== 32'h100) begin errors++; $display("FAIL arst_edge_reg4: got %h expected %h", dbg_val, 32'h100); end
        checks++; if (wr_count !== 32'h0) begin errors++; $display("FAIL arst_edge_count: got %0d expected %0d", wr_count, 0); end
        @(negedge clk);
        drive(0, 8'h0F, 0, 8'h0F, 0, 8'd0, 8'd0);
        rst = 1;
    endtask

    initial begin
        rst = 0;
        drive(0, 8'h0F, 0, 8'h0F, 0, 8'd0, 8'd0);
        dbg_id = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1;
        test_reset();
        test_dual_write();
        test_same_dst();
        test_stall();
        test_invalid();
        test_random();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Architectural register file for the Y86 pipeline; the consuming end of the write-back stage.
- Takes wb_valE/wb_dstE and wb_valM/wb_dstM from the MEM/WB stage and commits them on the clock edge.
- Serves two combinational read ports to decode, with same-cycle write-through bypass.
- Also provides a debug read port and a committed-write counter.

Parameters:
- NREG, 8, number of architectural registers (IDs 0..NREG-1: eax,ecx,edx,ebx,esp,ebp,esi,edi).
- RSP_ID, 4, register ID of the stack pointer.
- RSP_INIT, 32'h0000_0000, reset value of the stack pointer.
- RNONE, 8'h0F, "no register" ID.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- wb_stall  in  1  when 1, suppress all commits this cycle.
- wb_valE  in  `WORD  E-port write data.
- wb_valM  in  `WORD  M-port write data.
- wb_dstE  in  `BYTE  E-port destination ID.
- wb_dstM  in  `BYTE  M-port destination ID.
- srcA  in  `BYTE  read port A ID.
- srcB  in  `BYTE  read port B ID.
- valA  out  `WORD  read port A data.
- valB  out  `WORD  read port B data.
- dbg_id  in  `BYTE  debug read ID.
- dbg_val  out  `WORD  debug read data (stored value, no bypass).
- wr_count  out  `WORD  number of register commits since reset.

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-write):
  - Every register clears to 0, except reg[RSP_ID], which loads RSP_INIT.
  - wr_count clears to 0.
  - The clock edge during reset commits nothing.
- Write-enable decode:
  - weE = !wb_stall && wb_dstE < NREG; weM likewise for wb_dstM.
  - RNONE and any ID >= NREG mean no write (silently ignored).
- Commit, on a rising clk with rst=1:
  - weE: reg[wb_dstE] <= wb_valE.
  - weM: reg[wb_dstM] <= wb_valM.
  - Same destination on both ports: M wins (popl %esp semantics); E data is discarded for that edge.
- wr_count:
  - Increments by weE + weM each edge, so +2 for distinct destinations.
  - Same destination on both ports counts once (+1).
  - Wraps modulo 2^32 with no saturation.
- Read ports (combinational, zero latency):
  - srcX >= NREG (incl. RNONE): valX = 0.
  - Else if weM && wb_dstM == srcX: valX = wb_valM.
  - Else if weE && wb_dstE == srcX: valX = wb_valE.
  - Else valX = reg[srcX].
  - Bypass priority is M over E, matching commit priority.
  - With wb_stall=1 there is no bypass; the stored value is returned.
- Debug port: dbg_val = reg[dbg_id] if dbg_id < NREG, else 0; never bypassed.
- Outputs during reset: valA/valB/dbg_val reflect the reset register contents; bypass is disabled because writes are blocked.

Test Plan:
1. Release reset with RSP_INIT=32'h100. Read srcA=4, srcB=0 → valA=32'h100, valB=0, wr_count=0.
2. dstE=1/valE=32'h11 and dstM=2/valM=32'h22 in one cycle, srcA=1, srcB=2:
   - before the edge: valA=32'h11, valB=32'h22 (bypass).
   - after the edge: dbg_id=1 → 32'h11; wr_count=2.
3. dstE=dstM=4, valE=32'hFC, valM=32'hAA:
   - bypass on srcA=4 gives 32'hAA.
   - after the edge reg4=32'hAA; wr_count +1.
4. wb_stall=1 with dstE=3/valE=32'h33:
   - valA on srcA=3 stays at the old value; reg3 unchanged; wr_count unchanged.
   - deassert stall → commit occurs on the next edge.
5. dstE=RNONE, dstM=8'h09 with nonzero data → no register changes, wr_count unchanged; srcA=RNONE → valA=0.
6. Assert rst low mid-cycle after several writes → regs cleared and esp=RSP_INIT immediately, without waiting for a clock edge; wr_count=0.
